sipo_frame_rx: RTL and testbench
================================

// Module: sipo_frame_rx
// PURPOSE
//  - Serial-to-parallel frame receiver. Sits directly downstream of the 4-bit
//    parallel-in/serial-out shifter and consumes its LSB-first serial stream.
//  - Detects a start bit, shifts in WIDTH data bits, optionally checks parity,
//    and checks the stop bit.
//  - Presents each received word on a valid/ready output with error flags and
//    an overrun indication.
// PARAMETERS
//  WIDTH      4  data bits per frame, LSB first (2..16)
//  PARITY_EN  1  1 = one parity bit follows the data; 0 = no parity bit
//  PARITY_ODD 0  0 = even parity; 1 = odd parity (ignored when PARITY_EN=0)
// PORTS
//  clk         in   1      single clock, all logic on posedge
//  reset       in   1      synchronous, active-high
//  s_in        in   1      serial data bit
//  s_en        in   1      bit strobe: s_in is sampled only on cycles where s_en=1
//  data        out  WIDTH  received word, held stable while valid=1
//  valid       out  1      data/flags valid; held until accepted
//  ready       in   1      consumer accepts when valid&&ready on a clk edge
//  frame_err   out  1      stop bit was 0 for the word on data (qualified by valid)
//  parity_err  out  1      parity mismatch for the word on data (qualified by valid)
//  overrun     out  1      one-cycle pulse: completed frame dropped because valid&&!ready
//  busy        out  1      1 when state != IDLE
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, bit count=0, shift reg=0.
//    Outputs after reset: data=0, valid=0, frame_err=0, parity_err=0,
//    overrun=0, busy=0. Reset wins over every other event in the same cycle.
//  - Nothing changes on cycles with s_en=0, except that the output handshake
//    still proceeds.
//  - FSM:
//    - IDLE:   s_en && s_in==0 (start bit) -> DATA, count=0.
//              s_en && s_in==1 -> stay in IDLE (line idle).
//    - DATA:   on each s_en, shift_reg <= {s_in, shift_reg[WIDTH-1:1]}
//              (first bit lands in bit 0), then count++.
//              After the WIDTH-th bit: -> PARITY if PARITY_EN, else -> STOP.
//    - PARITY: on s_en, par_bad = (^shift_reg ^ s_in ^ PARITY_ODD) != 0 -> STOP.
//    - STOP:   on s_en, frame complete; frame_err_n = (s_in==0) -> IDLE.
//  - Completion: on the STOP sampling edge, data/flags load into the output
//    register on that same edge. valid=1 from the next cycle. Latency is one
//    clk after the stop bit is sampled.
//  - Handshake:
//    - valid stays 1, with data and flags constant, until a cycle with
//      valid&&ready. valid then drops on the next edge unless a new frame
//      completes on that edge.
//    - Completion while valid=0, or while valid&&ready in the same cycle:
//      load the new word; valid=1. No overrun.
//    - Completion while valid&&!ready: new word discarded, held word kept,
//      overrun=1 for exactly one cycle.
//  - A start bit may be sampled on the s_en immediately after STOP, so
//    back-to-back frames are allowed with no extra idle bits.
//  - s_en=1 on every cycle is legal (maximum rate).
//  - frame_err: the word is still delivered with frame_err=1. The FSM always
//    returns to IDLE; there is no hunt or resync logic.
//  - Reset mid-frame: the partial word is discarded, and any held output word
//    is discarded (valid=0).
// STRUCTURE
//  - Shared header shift_pkg.vh:
//    - FSM state localparams: ST_IDLE=2'd0, ST_DATA=2'd1, ST_PARITY=2'd2, ST_STOP=2'd3
//    - START_LEVEL=1'b0, STOP_LEVEL=1'b1
//    - default frame WIDTH=4
//  - One sub-module, rx_out_buf: the single-entry output holding register with
//    valid/ready and overrun generation. It is reusable by later receivers.
//  - Bit counter width is $clog2(WIDTH+1).
// TESTING (WIDTH=4, PARITY_EN=1, PARITY_ODD=0 unless noted)
//  1. s_en=1 every cycle, s_in=0,1,1,0,1,1,1 (start, 1011b LSB-first, parity=1,
//     stop), ready=1 -> data=4'hB, valid=1 for 1 cycle, both errors 0.
//  2. Same frame with parity bit 0 -> data=4'hB, parity_err=1, frame_err=0.
//     Same frame with stop bit 0 -> frame_err=1.
//  3. ready=0, two back-to-back frames 4'hB then 4'h5 -> data stays 4'hB,
//     valid=1, overrun pulses once when the second frame completes.
//     Raise ready -> valid drops the next cycle.
//  4. s_en toggling 1,0,0,1... with the frame from test 1 -> same result;
//     state and data are unchanged on s_en=0 cycles.
//  5. reset=1 for 1 cycle after 2 data bits -> busy=0 and valid=0 the next
//     cycle. A following full 4'h3 frame is received correctly.
//  6. PARITY_EN=0: s_in=0,0,1,0,1,1 -> data=4'hA, valid=1, 6 bit-times per frame.

Source files
------------

// File: rtl/sipo_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver.
//  - rx_state_e    : receiver FSM state encoding
//  - START_LEVEL   : line level of a start bit
//  - STOP_LEVEL    : line level of a valid stop bit
//  - DEFAULT_WIDTH : default number of data bits per frame
package sipo_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam logic START_LEVEL   = 1'b0;
  localparam logic STOP_LEVEL    = 1'b1;
  localparam int   DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sipo_frame_rx_out_buf.sv
// rx_out_buf: single-entry output holding register with valid/ready.
//  clk, reset : clock, synchronous active-high reset
//  load_i     : a completed word is offered this cycle
//  data_i     : offered word
//  ferr_i     : offered word had a bad stop bit
//  perr_i     : offered word had a parity mismatch
//  ready_i    : consumer accepts the held word when valid_o && ready_i
//  data_o     : held word, stable while valid_o=1
//  valid_o    : held word is valid
//  ferr_o     : frame error flag of the held word
//  perr_o     : parity error flag of the held word
//  overrun_o  : one-cycle pulse, an offered word was dropped
//
// Handshake: a word is transferred on a clk edge where valid_o && ready_i.
// While valid_o=1, data_o/ferr_o/perr_o do not change until that transfer.
module rx_out_buf #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ferr_i,
  input  logic         perr_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         ferr_o,
  output logic         perr_o,
  output logic         overrun_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ferr_q, ferr_d;
  logic         perr_q, perr_d;
  logic         ovr_q, ovr_d;

  // The slot is free if empty or being drained on this same edge.
  logic slot_free;
  assign slot_free = !valid_q || ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = 1'b0;
    if (load_i && slot_free) begin
      data_d  = data_i;
      ferr_d  = ferr_i;
      perr_d  = perr_i;
      valid_d = 1'b1;
    end else begin
      if (valid_q && ready_i) valid_d = 1'b0;
      // New word arrives while the held one is stuck: drop the new one.
      if (load_i) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign ferr_o    = ferr_q;
  assign perr_o    = perr_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-to-parallel frame receiver, LSB-first stream.
// Frame: start(0), WIDTH data bits, optional parity bit, stop(1).
//  clk, reset : clock, synchronous active-high reset
//  s_in, s_en : serial bit and its strobe (sampled only when s_en=1)
//  data       : received word (valid/ready output, held while valid=1)
//  valid      : data/flags valid until accepted
//  ready      : consumer ready
//  frame_err  : stop bit was 0 for the word on data
//  parity_err : parity mismatch for the word on data
//  overrun    : one-cycle pulse, completed frame dropped
//  busy       : FSM not idle
//  dbg_state  : current FSM state (rx_state_e encoding)
module sipo_frame_rx
  import sipo_frame_rx_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  input  logic             s_en,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int             CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  localparam logic           ODD_BIT = (PARITY_ODD != 0);

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_bad_q, par_bad_d;
  logic             done;
  logic             ferr_n;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    done      = 1'b0;
    ferr_n    = 1'b0;
    if (s_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (s_in == START_LEVEL) begin
            state_d   = ST_DATA;
            count_d   = '0;
            par_bad_d = 1'b0;
          end
        end
        ST_DATA: begin
          shift_d = {s_in, shift_q[WIDTH-1:1]};
          count_d = count_q + 1'b1;
          if (count_q == LAST) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          par_bad_d = (^shift_q) ^ s_in ^ ODD_BIT;
          state_d   = ST_STOP;
        end
        ST_STOP: begin
          done    = 1'b1;
          ferr_n  = (s_in != STOP_LEVEL);
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
    end
  end

  rx_out_buf #(.W(WIDTH)) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load_i    (done),
    .data_i    (shift_q),
    .ferr_i    (ferr_n),
    .perr_i    (par_bad_q),
    .ready_i   (ready),
    .data_o    (data),
    .valid_o   (valid),
    .ferr_o    (frame_err),
    .perr_o    (parity_err),
    .overrun_o (overrun)
  );

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
module tb_sipo_frame_rx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       s_in = 1'b1;
  logic       s_en = 1'b0;
  logic       s_en_b = 1'b0;
  logic       ready = 1'b1;

  logic [3:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ferr_a, ferr_b;
  logic       perr_a, perr_b;
  logic       ovr_a, ovr_b;
  logic       busy_a, busy_b;
  logic [1:0] st_a, st_b;

  sipo_frame_rx #(.WIDTH(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset(reset), .s_in(s_in), .s_en(s_en),
    .data(data_a), .valid(valid_a), .ready(ready),
    .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a),
    .busy(busy_a), .dbg_state(st_a)
  );

  sipo_frame_rx #(.WIDTH(4), .PARITY_EN(0), .PARITY_ODD(0)) dut_b (
    .clk(clk), .reset(reset), .s_in(s_in), .s_en(s_en_b),
    .data(data_b), .valid(valid_b), .ready(ready),
    .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b),
    .busy(busy_b), .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  // Drive bits[0..n-1] one per strobe, with `gap` idle cycles between bits.
  // Returns just after the edge that sampled the last bit.
  task automatic send_bits(input logic [15:0] bits, input int n, input int gap, input bit to_b);
    for (int i = 0; i < n; i++) begin
      if (to_b) s_en_b = 1'b1;
      else      s_en   = 1'b1;
      s_in = bits[i];
      tick();
      s_en   = 1'b0;
      s_en_b = 1'b0;
      s_in   = 1'b1;
      if (i < n - 1) repeat (gap) tick();
    end
  endtask

  initial begin
    // Reset state
    do_reset(2);
    check_eq("rst_data",    32'(data_a), 32'h0);
    check_eq("rst_valid",   32'(valid_a), 32'h0);
    check_eq("rst_ferr",    32'(ferr_a), 32'h0);
    check_eq("rst_perr",    32'(perr_a), 32'h0);
    check_eq("rst_ovr",     32'(ovr_a), 32'h0);
    check_eq("rst_busy",    32'(busy_a), 32'h0);

    // Test 1: 0,1,1,0,1,1,1 -> 4'hB, parity ok, stop ok
    ready = 1'b1;
    send_bits(16'h0076, 7, 0, 1'b0);
    exp_q.push_back(32'hB);
    check_eq("t1_valid", 32'(valid_a), 32'h1);
    check_eq("t1_data",  32'(data_a), exp_q.pop_front());
    check_eq("t1_perr",  32'(perr_a), 32'h0);
    check_eq("t1_ferr",  32'(ferr_a), 32'h0);
    check_eq("t1_ovr",   32'(ovr_a), 32'h0);
    check_eq("t1_busy",  32'(busy_a), 32'h0);
    tick();
    check_eq("t1_valid_drop", 32'(valid_a), 32'h0);

    // Test 2a: parity bit 0 -> parity error
    send_bits(16'h0056, 7, 0, 1'b0);
    check_eq("t2a_valid", 32'(valid_a), 32'h1);
    check_eq("t2a_data",  32'(data_a), 32'hB);
    check_eq("t2a_perr",  32'(perr_a), 32'h1);
    check_eq("t2a_ferr",  32'(ferr_a), 32'h0);
    tick();
    // Test 2b: stop bit 0 -> frame error
    send_bits(16'h0036, 7, 0, 1'b0);
    check_eq("t2b_valid", 32'(valid_a), 32'h1);
    check_eq("t2b_data",  32'(data_a), 32'hB);
    check_eq("t2b_ferr",  32'(ferr_a), 32'h1);
    check_eq("t2b_perr",  32'(perr_a), 32'h0);
    tick();
    check_eq("t2b_idle", 32'(st_a), 32'h0);

    // Test 3: ready=0, back-to-back 4'hB then 4'h5 -> overrun once
    ready = 1'b0;
    send_bits(16'h2576, 14, 0, 1'b0);
    check_eq("t3_ovr",   32'(ovr_a), 32'h1);
    check_eq("t3_valid", 32'(valid_a), 32'h1);
    check_eq("t3_data",  32'(data_a), 32'hB);
    check_eq("t3_perr",  32'(perr_a), 32'h0);
    tick();
    check_eq("t3_ovr_pulse", 32'(ovr_a), 32'h0);
    check_eq("t3_hold_valid", 32'(valid_a), 32'h1);
    check_eq("t3_hold_data",  32'(data_a), 32'hB);
    ready = 1'b1;
    tick();
    check_eq("t3_valid_drop", 32'(valid_a), 32'h0);

    // Test 4: strobe 1,0,0,1,... with the test 1 frame
    send_bits(16'h0006, 3, 2, 1'b0);       // start, 1, 1
    check_eq("t4_state", 32'(st_a), 32'h1);
    check_eq("t4_busy",  32'(busy_a), 32'h1);
    repeat (2) tick();
    check_eq("t4_state_hold", 32'(st_a), 32'h1);
    check_eq("t4_no_valid",   32'(valid_a), 32'h0);
    send_bits(16'h000E, 4, 2, 1'b0);       // 0, 1, parity 1, stop 1
    check_eq("t4_valid", 32'(valid_a), 32'h1);
    check_eq("t4_data",  32'(data_a), 32'hB);
    check_eq("t4_perr",  32'(perr_a), 32'h0);
    check_eq("t4_ferr",  32'(ferr_a), 32'h0);
    tick();

    // Test 5: held word plus partial frame, then reset pulse
    ready = 1'b0;
    send_bits(16'h0076, 7, 0, 1'b0);
    check_eq("t5_held", 32'(valid_a), 32'h1);
    send_bits(16'h0006, 3, 0, 1'b0);
    check_eq("t5_busy_pre", 32'(busy_a), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t5_busy",  32'(busy_a), 32'h0);
    check_eq("t5_valid", 32'(valid_a), 32'h0);
    check_eq("t5_data",  32'(data_a), 32'h0);
    ready = 1'b1;
    send_bits(16'h0046, 7, 0, 1'b0);       // 4'h3, parity 0
    check_eq("t5_valid2", 32'(valid_a), 32'h1);
    check_eq("t5_data2",  32'(data_a), 32'h3);
    check_eq("t5_perr2",  32'(perr_a), 32'h0);
    check_eq("t5_ferr2",  32'(ferr_a), 32'h0);
    tick();

    // Test 6: no parity, 0,0,1,0,1,1 -> 4'hA in 6 bit-times
    send_bits(16'h0014, 5, 0, 1'b1);
    check_eq("t6_busy_5",  32'(busy_b), 32'h1);
    check_eq("t6_state_5", 32'(st_b), 32'h3);
    check_eq("t6_valid_5", 32'(valid_b), 32'h0);
    send_bits(16'h0001, 1, 0, 1'b1);
    check_eq("t6_valid", 32'(valid_b), 32'h1);
    check_eq("t6_data",  32'(data_b), 32'hA);
    check_eq("t6_perr",  32'(perr_b), 32'h0);
    check_eq("t6_ferr",  32'(ferr_b), 32'h0);
    check_eq("t6_busy",  32'(busy_b), 32'h0);
    tick();
    check_eq("t6_valid_drop", 32'(valid_b), 32'h0);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
